// File: rtl/io_responder_pkg.sv
// Shared IO-bus definitions: data width and the responder's address map.
package io_responder_pkg;

  localparam int IO_W = 32;

  typedef logic [IO_W-1:0] io_word_t;

  localparam logic [7:0] io_led_addr       = 8'h00;
  localparam logic [7:0] io_out_ready_addr = 8'h04;
  localparam logic [7:0] io_seg_addr       = 8'h08;
  localparam logic [7:0] io_in_valid_addr  = 8'h0C;
  localparam logic [7:0] io_sw_data_addr   = 8'h10;
  localparam logic [7:0] io_cycles_addr    = 8'h14;

endpackage

// File: rtl/io_responder_btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse on each rising edge of the debounced level.
module io_responder_btn_debounce
  import io_responder_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;
  logic             deb_level;
  logic             deb_prev;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive cycles of a differing level; flip once it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      deb_level  <= 1'b0;
    end else if (sync_p1 == deb_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_MAX) begin
      stable_cnt <= '0;
      deb_level  <= sync_p1;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) deb_prev <= 1'b0;
    else     deb_prev <= deb_level;
  end

  // Both inputs are registers, so the pulse is glitch-free.
  assign btn_rise = deb_level & ~deb_prev;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED/seven-segment registers, switch handover
// with button-driven valid flags, cycle counter and the combinational read mux.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int SW_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      io_addr,
  input  logic [IO_W-1:0] io_dout,
  input  logic            io_we,
  input  logic            io_rd,
  output logic [IO_W-1:0] io_din,
  input  logic [SW_W-1:0] sw,
  input  logic            btn_in,
  input  logic            btn_out,
  output logic [SW_W-1:0] led,
  output logic [IO_W-1:0] seg_data,
  output logic            in_valid,
  output logic            out_valid
);

  logic [SW_W-1:0] sw_p0;
  logic [SW_W-1:0] sw_p1;
  logic [SW_W-1:0] sw_latch;
  io_word_t        cycle_cnt;
  logic            in_rise;
  logic            out_rise;
  logic            wr_led;
  logic            wr_seg;
  logic            rd_sw;

  io_responder_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_in (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_in),
    .btn_rise (in_rise)
  );

  io_responder_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_out (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_out),
    .btn_rise (out_rise)
  );

  // Full 8-bit decode; writes and reads to other addresses have no effect.
  assign wr_led = io_we && (io_addr == io_led_addr);
  assign wr_seg = io_we && (io_addr == io_seg_addr);
  assign rd_sw  = io_rd && (io_addr == io_sw_data_addr);

  // Two-stage synchroniser for the asynchronous switch bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  // Switch handover: a button edge latches the switches; setting beats the read-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_latch <= '0;
      in_valid <= 1'b0;
    end else if (in_rise) begin
      sw_latch <= sw_p1;
      in_valid <= 1'b1;
    end else if (rd_sw) begin
      in_valid <= 1'b0;
    end
  end

  // Output registers; a SEG write beats a coincident acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      seg_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_led) led <= io_dout[SW_W-1:0];
      if (wr_seg) begin
        seg_data  <= io_dout;
        out_valid <= 1'b1;
      end else if (out_rise) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Read mux depends only on the address, never on io_rd.
  always_comb begin
    io_din = '0;
    case (io_addr)
      io_out_ready_addr: io_din = {31'b0, ~out_valid};
      io_in_valid_addr:  io_din = {31'b0, in_valid};
      io_sw_data_addr:   io_din = IO_W'(sw_latch);
      io_cycles_addr:    io_din = cycle_cnt;
      default:           io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder with DEB_CYCLES = 4.
module tb_io_responder;

  localparam int DEB  = 4;
  localparam int SW_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      io_addr;
  logic [31:0]     io_dout;
  logic            io_we;
  logic            io_rd;
  logic [31:0]     io_din;
  logic [SW_W-1:0] sw;
  logic            btn_in;
  logic            btn_out;
  logic [SW_W-1:0] led;
  logic [31:0]     seg_data;
  logic            in_valid;
  logic            out_valid;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] tb_cyc;

  io_responder #(.DEB_CYCLES(DEB), .SW_W(SW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .sw        (sw),
    .btn_in    (btn_in),
    .btn_out   (btn_out),
    .led       (led),
    .seg_data  (seg_data),
    .in_valid  (in_valid),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference count of cycles since reset deassertion.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Read responses are compared mid-cycle against the queued expectations.
  always @(negedge clk) begin
    if (io_rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got read at addr %02h expected none", io_addr);
      end else begin
        check_val(tag_q.pop_front(), io_din, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    io_addr = addr;
    io_rd   = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    io_rd = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
    io_addr = addr;
    io_dout = data;
    io_we   = 1'b1;
    step();
    io_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; io_addr = 8'h00; io_dout = 32'd0; io_we = 1'b0; io_rd = 1'b0;
    sw = '0; btn_in = 1'b0; btn_out = 1'b0;
    step(3);
    rst = 1'b0;

    // Reset state and read map
    check_val("rst_led", 32'(led), 32'd0);
    check_val("rst_seg", seg_data, 32'd0);
    check_val("rst_in_valid", 32'(in_valid), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    do_read(8'h00, 32'd0, "rd_led_wo");
    do_read(8'h04, 32'd1, "rd_out_ready");
    do_read(8'h08, 32'd0, "rd_seg_wo");
    do_read(8'h0C, 32'd0, "rd_in_valid");
    do_read(8'h10, 32'd0, "rd_sw_data");
    do_read(8'h14, tb_cyc, "rd_cycles");

    // LED / SEG writes and btn_out acknowledge latency
    do_write(8'h00, 32'h0000A5A5);
    do_write(8'h08, 32'h12345678);
    check_val("led_wr", 32'(led), 32'h0000A5A5);
    check_val("seg_wr", seg_data, 32'h12345678);
    check_val("out_valid_set", 32'(out_valid), 32'd1);
    do_read(8'h04, 32'd0, "rd_out_ready_busy");
    btn_out = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        check_val("out_valid_before_ack", 32'(out_valid), 32'd1);
        btn_out = 1'b0;
      end
      if (k == 7) check_val("out_valid_ack", 32'(out_valid), 32'd0);
    end
    step(10);

    // Glitch rejection, then a clean press on btn_in
    sw = 16'h00FF;
    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    step(10);
    check_val("glitch_rejected", 32'(in_valid), 32'd0);
    btn_in = 1'b1;
    step(6);
    btn_in = 1'b0;
    step(2);
    check_val("in_valid_set", 32'(in_valid), 32'd1);
    do_read(8'h10, 32'h000000FF, "rd_sw_ff");
    check_val("in_valid_clr", 32'(in_valid), 32'd0);
    step(10);

    // Button edge coincident with a SW_DATA read: set wins
    sw = 16'h0F0F;
    step(3);
    btn_in = 1'b1;
    step(6);
    btn_in = 1'b0;
    do_read(8'h10, 32'h000000FF, "rd_sw_old");
    check_val("in_valid_set_wins", 32'(in_valid), 32'd1);
    do_read(8'h10, 32'h00000F0F, "rd_sw_new");
    check_val("in_valid_clr2", 32'(in_valid), 32'd0);
    step(10);

    // btn_out edge coincident with a SEG write: write wins
    btn_out = 1'b1;
    step(6);
    btn_out = 1'b0;
    do_write(8'h08, 32'hDEADBEEF);
    check_val("out_valid_wr_wins", 32'(out_valid), 32'd1);
    check_val("seg_deadbeef", seg_data, 32'hDEADBEEF);
    step(10);

    // Unmapped address: no effect, reads 0
    do_write(8'h20, 32'hFFFFFFFF);
    check_val("unmapped_led", 32'(led), 32'h0000A5A5);
    check_val("unmapped_seg", seg_data, 32'hDEADBEEF);
    check_val("unmapped_out_valid", 32'(out_valid), 32'd1);
    do_read(8'h20, 32'd0, "rd_unmapped");

    // Cycle counter wrap
    force dut.cycle_cnt = 32'hFFFFFFFE;
    #2;
    release dut.cycle_cnt;
    do_read(8'h14, 32'hFFFFFFFE, "cyc_fffe");
    do_read(8'h14, 32'hFFFFFFFF, "cyc_ffff");
    do_read(8'h14, 32'h00000000, "cyc_wrap");

    // Reset in the middle of a debounce count
    btn_in = 1'b1;
    step(4);
    rst = 1'b1;
    btn_in = 1'b0;
    step();
    rst = 1'b0;
    check_val("rst2_led", 32'(led), 32'd0);
    check_val("rst2_seg", seg_data, 32'd0);
    check_val("rst2_out_valid", 32'(out_valid), 32'd0);
    check_val("rst2_in_valid", 32'(in_valid), 32'd0);
    step(12);
    check_val("rst2_no_edge", 32'(in_valid), 32'd0);
    do_read(8'h0C, 32'd0, "rd_in_valid_rst2");
    do_read(8'h10, 32'd0, "rd_sw_rst2");

    step(2);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
